gpio_port: RTL
==============

Name: gpio_port

Overview:
- Parametrised general-purpose I/O peripheral on the CPU's memory-mapped peripheral bus (cs/wr/addr/wdata/rdata).
- Successor to the fixed 16-bit output-only port. Adds:
  - configurable pin count
  - per-pin direction
  - synchronised input readback
  - atomic set/clear/toggle of output bits
  - per-pin rising-edge interrupt with pending flags and a combined IRQ line.

Parameters:
- WIDTH, 16, number of pins (1..32). Bits above WIDTH-1 read 0 and ignore writes.
- RST_ODR, 0, reset value of the output data register (WIDTH bits).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears/initialises all registers
- cs  input  1  peripheral select
- wr  input  1  write strobe; a write occurs on a clk edge with cs & wr = 1
- addr  input  3  word register index
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr (valid whenever cs = 1; cs not required for value)
- gpio_in  input  WIDTH  raw pin inputs, asynchronous to clk
- gpio_out  output  WIDTH  output drive value = ODR
- gpio_oe  output  WIDTH  output enable = MODER (1 = drive pin)
- irq  output  1  interrupt request = |(ISR & IER), combinational from registers

Behaviour:
Register map (addr):
- 0 MODER, RW: direction, 1 = output. Reset 0 (all inputs).
- 1 ODR, RW: output data. Reset RST_ODR.
- 2 IDR, RO: synchronised input (second sync stage). Writes ignored.
- 3 SET, WO: ODR |= wdata. Reads 0.
- 4 CLR, WO: ODR &= ~wdata. Reads 0.
- 5 TGL, WO: ODR ^= wdata. Reads 0.
- 6 IER, RW: per-pin interrupt enable. Reset 0.
- 7 ISR, R/W1C: rising-edge pending flags. Writing 1 clears the bit; writing 0 has no effect. Reset 0.

Register widths and write timing:
- All registers are WIDTH bits; rdata is zero-extended to 32 bits. Only wdata[WIDTH-1:0] is used.
- A register write takes effect at the clk edge where cs & wr = 1. Readback shows the new value in the following cycle.
- gpio_out and gpio_oe follow ODR and MODER with no extra latency beyond the register.

Input path:
- Two-flop synchroniser per pin (sync1, sync2) plus a delay flop sync3. IDR = sync2.
- Edge detect: rise = sync2 & ~sync3. At each clk edge, ISR |= rise.
- A pin level change sampled at edge E1 is visible in IDR after E2, sets ISR after E3, and raises irq after E3 if IER is set.
- Edge detection runs regardless of MODER, so an output pin looped back to its input also generates edges.

Simultaneous events:
- ISR set and W1C clear on the same bit in the same cycle: the set wins, so the bit stays 1 and no edge is lost.
- The SET, CLR and TGL registers are distinct addresses, so only one of them can act per cycle. No conflict arises.
- IER cleared while ISR is pending: irq drops in the next cycle, and ISR keeps its value.

Reset:
- Reset asserted at any time, including mid-write, immediately forces:
  - MODER = 0
  - ODR = RST_ODR
  - IER = 0
  - ISR = 0
  - sync1, sync2, sync3 = 0
- Outputs after reset: gpio_oe = 0, gpio_out = RST_ODR, irq = 0.
- A pin held high across reset release produces one rising edge and sets ISR. This is intended and documented for software.

Test Plan:
- Reset with WIDTH = 16, RST_ODR = 16'h00A5 → gpio_out = 00A5, gpio_oe = 0, irq = 0; read addr 1 = 0x000000A5, read addr 7 = 0.
- Write MODER = FFFF, ODR = 1234, then SET 0x8001 → gpio_out = 9235; CLR 0x0234 → 9001; TGL 0xFFFF → 6FFE. Reads of addrs 3, 4, 5 return 0. Write wdata = 0xFFFF0000 to ODR → ODR = 0000.
- gpio_in[3] goes 0→1 between edges → IDR bit 3 reads 1 two edges later. ISR = 0x0008 after the third edge. irq stays 0 until IER = 0x0008 is written, then irq = 1.
- With ISR[3] = 1, write ISR = 0x0008 in the same cycle a new rising edge on pin 3 is detected → ISR[3] remains 1. Repeat without the edge → ISR = 0 and irq = 0 next cycle.
- Pulse gpio_in[0] high for one clk period only, and also hold a pin high with no transition → a single-cycle pulse, if sampled, sets ISR[0] exactly once. A steady-high pin sets no further flags after the first edge is cleared.
- Assert reset asynchronously mid-cycle during a write to ODR with IER = FFFF and ISR pending → all outputs reach their reset values before the next clk edge. The write is discarded and irq = 0.

Source files
------------

// File: rtl/gpio_port_if.sv
// rtl/gpio_port_if.sv - memory-mapped peripheral bus between CPU and gpio_port
interface gpio_port_if;
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output wr, output addr, output wdata, input rdata);
    modport slave  (input cs, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - parametrised GPIO port with direction, sync input, set/clr/tgl and edge IRQ
module gpio_port #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_ODR = '0
) (
    input  logic             clk,
    input  logic             reset,
    gpio_port_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] A_MODER = 3'd0;
    localparam logic [2:0] A_ODR   = 3'd1;
    localparam logic [2:0] A_IDR   = 3'd2;
    localparam logic [2:0] A_SET   = 3'd3;
    localparam logic [2:0] A_CLR   = 3'd4;
    localparam logic [2:0] A_TGL   = 3'd5;
    localparam logic [2:0] A_IER   = 3'd6;
    localparam logic [2:0] A_ISR   = 3'd7;

    logic [WIDTH-1:0] moder, odr, ier, isr;
    logic [WIDTH-1:0] sync1, sync2, sync3;
    logic [WIDTH-1:0] wd, rise, rd_w;
    logic             we;
    logic             unused_wdata;

    assign we           = bus.cs & bus.wr;
    assign wd           = bus.wdata[WIDTH-1:0];
    assign unused_wdata = ^bus.wdata;
    assign rise         = sync2 & ~sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            moder <= '0;
            odr   <= RST_ODR;
            ier   <= '0;
            isr   <= '0;
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            sync3 <= sync2;
            // A new edge is OR-ed in after the W1C mask so it is never lost
            if (we && bus.addr == A_ISR)
                isr <= (isr & ~wd) | rise;
            else
                isr <= isr | rise;
            if (we) begin
                case (bus.addr)
                    A_MODER: moder <= wd;
                    A_ODR:   odr   <= wd;
                    A_SET:   odr   <= odr | wd;
                    A_CLR:   odr   <= odr & ~wd;
                    A_TGL:   odr   <= odr ^ wd;
                    A_IER:   ier   <= wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_w = '0;
        case (bus.addr)
            A_MODER: rd_w = moder;
            A_ODR:   rd_w = odr;
            A_IDR:   rd_w = sync2;
            A_IER:   rd_w = ier;
            A_ISR:   rd_w = isr;
            default: rd_w = '0;
        endcase
    end

    assign bus.rdata = 32'(rd_w);
    assign gpio_out  = odr;
    assign gpio_oe   = moder;
    assign irq       = |(isr & ier);
endmodule
